// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : Instruction-memory requester front end. Drives the word
//                address, captures the word returned one cycle later into a
//                2-entry {word, pc} buffer, and presents instructions to
//                decode over valid/ready. Redirects are zero-bubble: the
//                target address goes to memory in the same cycle.
//                Optional macro IFETCH_PERF_EN adds fetch/stall counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 10,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] dataIn,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_addr,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_pc
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0]           perf_fetch_count,
   output logic [31:0]           perf_stall_count
`endif
);

   logic [ADDR_WIDTH-1:0] fetch_pc_q;
   logic [ADDR_WIDTH-1:0] fetch_pc_d;
   logic                  req_q;
   logic [ADDR_WIDTH-1:0] req_pc_q;

   logic [DATA_WIDTH-1:0] word_q [2];
   logic [ADDR_WIDTH-1:0] pc_q   [2];
   logic                  rd_ptr_q;
   logic                  wr_ptr_q;
   logic [1:0]            count_q;
   logic [1:0]            count_d;

   logic                  pop;
   logic                  push;
   logic                  issue;
   logic [2:0]            occupancy;

   // Handshake and issue decisions; a redirect overrides pop/push and forces issue
   always_comb begin
      address     = redirect_valid ? redirect_addr : fetch_pc_q;
      instr_valid = (count_q != 2'd0);
      instr       = word_q[rd_ptr_q];
      instr_pc    = pc_q[rd_ptr_q];
      pop         = instr_valid & instr_ready & ~redirect_valid;
      push        = req_q & ~redirect_valid;
      // Slots already committed (buffered + in flight) after this cycle's pop;
      // only issue if the word returning next cycle is guaranteed a slot.
      occupancy   = {1'b0, count_q} + {2'b00, req_q} - {2'b00, pop};
      issue       = redirect_valid | (occupancy < 3'd2);
      fetch_pc_d  = issue ? (address + ADDR_WIDTH'(1)) : fetch_pc_q;
      count_d     = count_q + {1'b0, push} - {1'b0, pop};
   end

   // Program counter and in-flight request tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_ADDR;
         req_q      <= 1'b0;
         req_pc_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         req_q      <= issue;
         if (issue) begin
            req_pc_q <= address;
         end
      end
   end

   // Two-entry return buffer; a redirect empties it and drops the in-flight word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            word_q[i] <= '0;
            pc_q[i]   <= '0;
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (redirect_valid) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            word_q[wr_ptr_q] <= dataIn;
            pc_q[wr_ptr_q]   <= req_pc_q;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

`ifdef IFETCH_PERF_EN
   // Accepted-instruction and decode-stall counters; redirect cycles are not counted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_count <= 32'd0;
         perf_stall_count <= 32'd0;
      end else if (!redirect_valid) begin
         if (pop) begin
            perf_fetch_count <= perf_fetch_count + 32'd1;
         end
         if (instr_valid && !instr_ready) begin
            perf_stall_count <= perf_stall_count + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch
//  Description : Self-checking bench for instruction_fetch: directed
//                cycle table, async reset sequence, wrap-around instance
//                (RESET_ADDR=1021) and a randomized run against an
//                instruction-stream reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst_n;

   logic [9:0]  address0, redirect_addr0, instr_pc0;
   logic [31:0] data0, instr0;
   logic        redirect_valid0, instr_valid0, instr_ready0;

   logic [9:0]  address1, redirect_addr1, instr_pc1;
   logic [31:0] data1, instr1;
   logic        redirect_valid1, instr_valid1, instr_ready1;

`ifdef IFETCH_PERF_EN
   logic [31:0] perf_fetch0, perf_stall0, perf_fetch1, perf_stall1;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   instruction_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RESET_ADDR(10'd0)) dut0 (
      .clk(clk), .rst_n(rst_n), .address(address0), .dataIn(data0),
      .redirect_valid(redirect_valid0), .redirect_addr(redirect_addr0),
      .instr_valid(instr_valid0), .instr_ready(instr_ready0),
      .instr(instr0), .instr_pc(instr_pc0)
`ifdef IFETCH_PERF_EN
      , .perf_fetch_count(perf_fetch0), .perf_stall_count(perf_stall0)
`endif
   );

   instruction_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RESET_ADDR(10'd1021)) dut1 (
      .clk(clk), .rst_n(rst_n), .address(address1), .dataIn(data1),
      .redirect_valid(redirect_valid1), .redirect_addr(redirect_addr1),
      .instr_valid(instr_valid1), .instr_ready(instr_ready1),
      .instr(instr1), .instr_pc(instr_pc1)
`ifdef IFETCH_PERF_EN
      , .perf_fetch_count(perf_fetch1), .perf_stall_count(perf_stall1)
`endif
   );

   // Instruction memory: word[k] = k + 0x100, one-cycle read latency
   always @(posedge clk) begin
      data0 <= {22'd0, address0} + 32'h100;
      data1 <= {22'd0, address1} + 32'h100;
   end

   function automatic logic [31:0] word_of(input logic [9:0] a);
      return {22'd0, a} + 32'h100;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       rdy;
      logic       rv;
      logic [9:0] raddr;
      logic       ev;
      logic [9:0] epc;
      logic [9:0] eaddr;
   } vec_t;

   function automatic vec_t mk(input logic rdy, input logic rv, input logic [9:0] ra,
                               input logic ev, input logic [9:0] epc, input logic [9:0] ea);
      vec_t v;
      v.rdy = rdy; v.rv = rv; v.raddr = ra; v.ev = ev; v.epc = epc; v.eaddr = ea;
      return v;
   endfunction

   vec_t vecs [24];

   logic [9:0] exp_pc;
   logic [9:0] ra;
   logic       rdy, rv;
   int         since;
   int         pops, stalls;

   initial begin
      // Directed cycle table starting at the cycle reset is released
      vecs[0]  = mk(1, 0, 10'h000, 0, 10'h000, 10'h000);
      vecs[1]  = mk(1, 0, 10'h000, 0, 10'h000, 10'h001);
      vecs[2]  = mk(0, 0, 10'h000, 1, 10'h000, 10'h002);
      vecs[3]  = mk(0, 0, 10'h000, 1, 10'h000, 10'h002);
      vecs[4]  = mk(0, 0, 10'h000, 1, 10'h000, 10'h002);
      vecs[5]  = mk(0, 0, 10'h000, 1, 10'h000, 10'h002);
      vecs[6]  = mk(0, 0, 10'h000, 1, 10'h000, 10'h002);
      vecs[7]  = mk(1, 0, 10'h000, 1, 10'h000, 10'h002);
      vecs[8]  = mk(1, 0, 10'h000, 1, 10'h001, 10'h003);
      vecs[9]  = mk(1, 0, 10'h000, 1, 10'h002, 10'h004);
      vecs[10] = mk(0, 0, 10'h000, 1, 10'h003, 10'h005);
      vecs[11] = mk(0, 1, 10'h200, 1, 10'h003, 10'h200);
      vecs[12] = mk(1, 0, 10'h000, 0, 10'h000, 10'h201);
      vecs[13] = mk(1, 0, 10'h000, 1, 10'h200, 10'h202);
      vecs[14] = mk(1, 0, 10'h000, 1, 10'h201, 10'h203);
      vecs[15] = mk(1, 0, 10'h000, 1, 10'h202, 10'h204);
      vecs[16] = mk(1, 1, 10'h050, 1, 10'h203, 10'h050);
      vecs[17] = mk(1, 1, 10'h3FF, 0, 10'h000, 10'h3FF);
      vecs[18] = mk(1, 0, 10'h000, 0, 10'h000, 10'h000);
      vecs[19] = mk(1, 0, 10'h000, 1, 10'h3FF, 10'h001);
      vecs[20] = mk(1, 0, 10'h000, 1, 10'h000, 10'h002);
      vecs[21] = mk(1, 0, 10'h000, 1, 10'h001, 10'h003);
      vecs[22] = mk(0, 0, 10'h000, 1, 10'h002, 10'h004);
      vecs[23] = mk(0, 0, 10'h000, 1, 10'h002, 10'h004);

      rst_n = 1'b0;
      instr_ready0 = 1'b1; redirect_valid0 = 1'b0; redirect_addr0 = '0;
      instr_ready1 = 1'b1; redirect_valid1 = 1'b0; redirect_addr1 = '0;
      repeat (2) @(negedge clk);
      #1;
      check("reset valid", {31'd0, instr_valid0}, 32'd0);
      check("reset address", {22'd0, address0}, 32'd0);
      check("reset instr", instr0, 32'd0);
      check("reset instr_pc", {22'd0, instr_pc0}, 32'd0);
      check("reset address wrapinst", {22'd0, address1}, 32'd1021);

      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 24; k++) begin
         instr_ready0    = vecs[k].rdy;
         redirect_valid0 = vecs[k].rv;
         redirect_addr0  = vecs[k].raddr;
         #1;
         check($sformatf("row%0d valid", k), {31'd0, instr_valid0}, {31'd0, vecs[k].ev});
         check($sformatf("row%0d address", k), {22'd0, address0}, {22'd0, vecs[k].eaddr});
         if (vecs[k].ev) begin
            check($sformatf("row%0d instr_pc", k), {22'd0, instr_pc0}, {22'd0, vecs[k].epc});
            check($sformatf("row%0d instr", k), instr0, word_of(vecs[k].epc));
         end
         if (k <= 6) begin
            check($sformatf("wrap row%0d address", k), {22'd0, address1}, (1021 + k) % 1024);
         end
         if (k >= 2 && k <= 6) begin
            check($sformatf("wrap row%0d valid", k), {31'd0, instr_valid1}, 32'd1);
            check($sformatf("wrap row%0d instr_pc", k), {22'd0, instr_pc1}, (1021 + k - 2) % 1024);
         end
         if (k < 23) @(negedge clk);
      end

      // Asynchronous reset mid-stream with a full buffer, checked before any edge
      #2 rst_n = 1'b0;
      #1;
      check("async reset valid", {31'd0, instr_valid0}, 32'd0);
      check("async reset address", {22'd0, address0}, 32'd0);
      check("async reset instr_pc", {22'd0, instr_pc0}, 32'd0);
      check("async reset address wrapinst", {22'd0, address1}, 32'd1021);
      instr_ready0 = 1'b1; redirect_valid0 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("restart c%0d address", k), {22'd0, address0}, k);
         check($sformatf("restart c%0d valid", k), {31'd0, instr_valid0}, (k >= 2) ? 32'd1 : 32'd0);
         if (k >= 2) check($sformatf("restart c%0d instr", k), instr0, 32'h100 + k - 2);
         @(negedge clk);
      end

      // Randomized run against an instruction-stream model: decode must see
      // consecutive words from the last reset/redirect target, in order.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_pc = 10'd0; since = 0; pops = 0; stalls = 0;
      for (int c = 0; c < 3000; c++) begin
         rdy = ($urandom_range(0, 9) < 7);
         rv  = ($urandom_range(0, 15) == 0);
         ra  = 10'($urandom);
         instr_ready0 = rdy; redirect_valid0 = rv; redirect_addr0 = ra;
         #1;
         if (rv) begin
            check("rand redirect address", {22'd0, address0}, {22'd0, ra});
            exp_pc = ra;
            since  = 0;
         end else begin
            if (since >= 2) check("rand valid latency", {31'd0, instr_valid0}, 32'd1);
            if (instr_valid0 && rdy) begin
               check("rand instr_pc", {22'd0, instr_pc0}, {22'd0, exp_pc});
               check("rand instr", instr0, word_of(exp_pc));
               exp_pc = exp_pc + 10'd1;
               pops++;
            end
            if (instr_valid0 && !rdy) stalls++;
         end
         since++;
         @(negedge clk);
      end
      instr_ready0 = 1'b0; redirect_valid0 = 1'b0;
`ifdef IFETCH_PERF_EN
      #1;
      check("perf fetch count", perf_fetch0, pops);
      check("perf stall count", perf_stall0, stalls);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
